// File: rtl/adc_muestreo_if.sv
// Bundle between the ADC sampler and its neighbours: the SPI pins toward the
// converter and the listo/y sample handshake toward the servo controller.
interface adc_muestreo_if;
  logic        en;
  logic        sdata;
  logic        cs_n;
  logic        sclk;
  logic [10:0] y;
  logic        listo;

  modport master (
    input  en,
    input  sdata,
    output cs_n,
    output sclk,
    output y,
    output listo
  );

  modport slave (
    output en,
    output sdata,
    input  cs_n,
    input  sclk,
    input  y,
    input  listo
  );
endinterface

// File: rtl/adc_muestreo.sv
// Periodic 3-wire SPI reader for a 12-bit serial ADC; publishes code[11:1]
// on y together with a one-cycle listo strobe.
module adc_muestreo #(
  parameter int DIV           = 5,
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic          clk,
  input  logic          rst,
  adc_muestreo_if.master bus
);

  localparam int PC_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(SAMPLE_PERIOD - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DIV - 1);
  localparam logic [5:0]      HP_LAST = 6'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [DC_W-1:0] dc_q, dc_d;
  logic [5:0]      hp_q, hp_d;
  logic [15:0]     sh_q, sh_d;
  logic            cs_n_q, cs_n_d;
  logic            sclk_q, sclk_d;
  logic [10:0]     y_q, y_d;
  logic            listo_q, listo_d;
  logic            tick;
  logic            sh_top_unused;

  // The oldest leading-zero bit falls off the top of the frame register.
  assign sh_top_unused = sh_q[15];

  assign tick = bus.en && (pc_q == PC_LAST);

  always_comb begin
    pc_d = pc_q;
    if (!bus.en) begin
      pc_d = '0;
    end else if (pc_q == PC_LAST) begin
      pc_d = '0;
    end else begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dc_d    = dc_q;
    hp_d    = hp_q;
    sh_d    = sh_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    y_d     = y_q;
    listo_d = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (tick) begin
          state_d = SHIFT;
          cs_n_d  = 1'b0;
          hp_d    = '0;
          dc_d    = '0;
        end
      end

      SHIFT: begin
        if (dc_q == DC_LAST) begin
          dc_d   = '0;
          sclk_d = ~sclk_q;
          hp_d   = hp_q + 6'd1;
          // Capture on the edge that raises sclk; the ADC launched the bit on the prior fall.
          if (!sclk_q) begin
            sh_d = {sh_q[14:0], bus.sdata};
          end
          if (hp_q == HP_LAST) begin
            cs_n_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          dc_d = dc_q + 1'b1;
        end
      end

      DONE: begin
        y_d     = sh_q[11:1];
        listo_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      dc_q    <= '0;
      hp_q    <= '0;
      sh_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      y_q     <= '0;
      listo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dc_q    <= dc_d;
      hp_q    <= hp_d;
      sh_q    <= sh_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      y_q     <= y_d;
      listo_q <= listo_d;
    end
  end

  assign bus.cs_n  = cs_n_q;
  assign bus.sclk  = sclk_q;
  assign bus.y     = y_q;
  assign bus.listo = listo_q;

endmodule

// File: tb/tb_adc_muestreo.sv
// Directed bench for adc_muestreo: serial ADC model, SPI/strobe monitor and
// hand-computed sample values and timings.
module tb_adc_muestreo;

  localparam int DIV = 2;
  localparam int SP  = 82;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adc_muestreo_if bus();

  adc_muestreo #(
    .DIV           (DIV),
    .SAMPLE_PERIOD (SP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Cycle count since reset release (posedges with rst high).
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // ADC model: a new frame on cs_n fall, next bit launched on every sclk fall, MSB first.
  logic [15:0] frames[$];
  logic [15:0] cur_frame = 16'h0000;
  int          nfall     = 0;
  always @(negedge bus.cs_n or negedge bus.sclk) begin
    if (bus.sclk) begin
      cur_frame = (frames.size() > 0) ? frames.pop_front() : 16'h0000;
      nfall     = 0;
      bus.sdata = 1'b0;
    end else if (!bus.cs_n && nfall < 16) begin
      bus.sdata = cur_frame[15 - nfall];
      nfall++;
    end
  end

  // Monitor sampled on the falling clk edge.
  int fall_cyc = 0, fall_cnt = 0, run = 0, rises = 0, phase_ok = 0, low_len = 0;
  int listo_cnt = 0, last_listo_cyc = 0, prev_listo_cyc = 0, listo_y = 0, listo_wide = 0;
  logic cs_prev = 1'b1, sclk_prev = 1'b1, listo_prev = 1'b0;
  always @(negedge clk) begin
    if (cs_prev && !bus.cs_n) begin
      fall_cyc = cyc;
      fall_cnt++;
      run      = 1;
      rises    = 0;
      phase_ok = 1;
    end else if (!cs_prev) begin
      if (bus.sclk != sclk_prev) begin
        if (run != DIV) phase_ok = 0;
        run = 1;
        if (bus.sclk) rises++;
      end else begin
        run++;
      end
      if (bus.cs_n) low_len = cyc - fall_cyc;
    end
    if (bus.listo) begin
      if (listo_prev) listo_wide = 1;
      listo_cnt++;
      prev_listo_cyc = last_listo_cyc;
      last_listo_cyc = cyc;
      listo_y        = int'(bus.y);
    end
    cs_prev    = bus.cs_n;
    sclk_prev  = bus.sclk;
    listo_prev = bus.listo;
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_listo(input int base, input string tag);
    int k = 0;
    while (listo_cnt <= base && k < 400) begin
      tick_n(1);
      k++;
    end
    check_val(tag, int'(listo_cnt > base), 1);
  endtask

  task automatic wait_fall(input int base, input string tag);
    int k = 0;
    while (fall_cnt <= base && k < 400) begin
      tick_n(1);
      k++;
    end
    check_val(tag, int'(fall_cnt > base), 1);
  endtask

  int n, f, en_cyc;

  initial begin
    bus.en = 1'b1;
    rst    = 1'b0;
    tick_n(3);
    check_val("rst_cs_n",  int'(bus.cs_n),  1);
    check_val("rst_sclk",  int'(bus.sclk),  1);
    check_val("rst_y",     int'(bus.y),     0);
    check_val("rst_listo", int'(bus.listo), 0);

    // Reset release and three back-to-back conversions.
    frames.push_back(16'h0C8A);
    frames.push_back(16'h0FFF);
    frames.push_back(16'h0001);
    rst = 1'b1;
    wait_listo(0, "listo1_seen");
    check_val("first_cs_fall_cyc", fall_cyc, 82);
    check_val("cs_low_len",        low_len, 64);
    check_val("sclk_rises",        rises, 16);
    check_val("sclk_phase_ok",     phase_ok, 1);
    check_val("listo_latency",     last_listo_cyc - fall_cyc, 65);
    check_val("y_c8a",             listo_y, 1605);
    check_val("y_after_strobe",    int'(bus.y), 1605);
    check_val("listo_low_next",    int'(bus.listo), 0);

    wait_listo(1, "listo2_seen");
    check_val("y_fff",       listo_y, 2047);
    check_val("spacing_1_2", last_listo_cyc - prev_listo_cyc, 82);
    wait_listo(2, "listo3_seen");
    check_val("y_001",       listo_y, 0);
    check_val("spacing_2_3", last_listo_cyc - prev_listo_cyc, 82);
    check_val("listo_width", listo_wide, 0);

    // Drop enable ten cycles into a frame with leading ones.
    frames.push_back(16'hF7FE);
    f = fall_cnt;
    n = listo_cnt;
    wait_fall(f, "fall4_seen");
    tick_n(9);
    bus.en = 1'b0;
    wait_listo(n, "listo4_seen");
    check_val("y_f7fe",         listo_y, 1023);
    check_val("listo4_latency", last_listo_cyc - fall_cyc, 65);
    check_val("sclk_rises4",    rises, 16);
    f = fall_cnt;
    tick_n(300);
    check_val("no_cs_while_off", fall_cnt, f);
    check_val("cs_n_idle_off",   int'(bus.cs_n), 1);
    check_val("y_hold_off",      int'(bus.y), 1023);

    // Re-enable: next conversion starts SAMPLE_PERIOD cycles later.
    frames.push_back(16'h0123);
    n      = listo_cnt;
    en_cyc = cyc;
    bus.en = 1'b1;
    wait_fall(f, "fall5_seen");
    check_val("reenable_fall_delay", fall_cyc - en_cyc, 82);
    wait_listo(n, "listo5_seen");
    check_val("y_123", listo_y, 145);

    // Reset around hp=17 of the next frame.
    frames.push_back(16'h0ABC);
    frames.push_back(16'h0456);
    f = fall_cnt;
    wait_fall(f, "fall6_seen");
    tick_n(33);
    n   = listo_cnt;
    rst = 1'b0;
    #1;
    check_val("midrst_cs_n",  int'(bus.cs_n),  1);
    check_val("midrst_sclk",  int'(bus.sclk),  1);
    check_val("midrst_y",     int'(bus.y),     0);
    check_val("midrst_listo", int'(bus.listo), 0);
    tick_n(5);
    check_val("no_strobe_abort", listo_cnt, n);
    rst = 1'b1;
    wait_listo(n, "listo7_seen");
    check_val("y_456",               listo_y, 555);
    check_val("post_rst_listo_cyc",  last_listo_cyc, 147);
    check_val("post_rst_cs_low_len", low_len, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_muestreo.md
# adc_muestreo

Position-sensor front end for the servo loop. It periodically reads a 12-bit serial ADC (ADCS7476-style, PmodAD1) over a 3-wire SPI read and scales the result to 11 bits. It then presents the sample on `y` with a one-cycle `listo` strobe. This is the producer side of the `listo`/`y` handshake that the `IPD_trunc` controller consumes.

## Interface
- `DIV`, default 5: clk cycles per SCLK half-period; must be ≥1 (5 gives 10 MHz SCLK at 100 MHz).
- `SAMPLE_PERIOD`, default 100000: clk cycles between conversion starts; must be ≥ 32*DIV+18 so that the controller gets ≥16 cycles between strobes.
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: sampling enable.
- `sdata`, in, 1: ADC serial data out.
- `cs_n`, out, 1: ADC chip select, active low.
- `sclk`, out, 1: ADC serial clock; idles high.
- `y`, out, 11: latest sample, unsigned, equal to ADC code[11:1].
- `listo`, out, 1: one-cycle strobe marking that `y` has just been updated.

## Operation
- **Period counter `pc`:**
  - Counts 0..SAMPLE_PERIOD-1 and wraps.
  - Held at 0 while `en`=0.
  - `tick` = `en` & (`pc`==SAMPLE_PERIOD-1).
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `cs_n`=1, `sclk`=1, `listo`=0.
  - On `tick`: next cycle `cs_n`=0, half-period counter `hp`=0, divider `dc`=0, go to SHIFT.
- **SHIFT:**
  - `dc` counts 0..DIV-1. When `dc`==DIV-1, toggle `sclk` and increment `hp`.
  - The first toggle drives `sclk` low.
  - On each low→high toggle (odd `hp`), shift `sdata` into the 16-bit register `sh` from the LSB side, so the MSB arrives first.
  - After the 32nd toggle (16th rising edge, `sclk` high again): `cs_n`=1, go to DONE.
- **DONE:** for one cycle, `y` <= `sh`[11:1] and `listo`=1, then go to IDLE.
- **Frame format:** `sh`[15:12] are the ADC leading zeros and are ignored. `sh`[11:0] is the 12-bit code, and its LSB is discarded (truncation, no rounding).
- **Missed ticks:** a `tick` that arrives in SHIFT or DONE is dropped and not queued. This cannot occur when `SAMPLE_PERIOD` is legal.
- **`en` falling mid-conversion:** the current conversion completes and strobes `listo`; no new conversion starts.
- **`y` hold:** `y` keeps its last value between strobes and while disabled.
- **Reset (asynchronous, any state):**
  - State returns to IDLE.
  - `cs_n`=1, `sclk`=1, `listo`=0, `y`=0.
  - `pc`, `dc`, `hp` and `sh` all clear to 0.
  - An aborted frame produces no strobe.

## Timing
- **Reset values:** `cs_n`=1, `sclk`=1, `y`=11'd0, `listo`=0.
- **First tick:** the first `tick` occurs SAMPLE_PERIOD-1 cycles after reset release, given `en`=1.
- **Start:** `cs_n` falls on the edge after `tick`.
- **Chip-select width:** `cs_n` is low for exactly 32*DIV cycles.
- **SCLK shape:** each SCLK phase lasts DIV cycles. The first SCLK fall occurs DIV cycles after `cs_n` falls.
- **Data capture:** `sdata` is sampled on the same clk edge that drives `sclk` high. The ADC changes data on SCLK fall, giving DIV cycles of setup.
- **End of frame:** `cs_n` rises together with the 16th `sclk` rise.
- **Latency:** `listo`=1 and the new `y` become visible in the cycle after `cs_n` rises, i.e. 32*DIV+1 cycles after `cs_n` falls and 32*DIV+2 cycles after `tick`.
- **Strobe width:** `listo` is high for exactly 1 cycle.
- **Strobe spacing:** consecutive strobes are exactly SAMPLE_PERIOD cycles apart while `en`=1.
- **Consumer contract:** `y` is stable from the `listo` cycle until the next strobe, so the consumer may latch it on `listo` or at any later cycle.

## Test plan
- **Reset and first conversion:** DIV=2, SAMPLE_PERIOD=82, ADC model returns code 12'hC8A (frame 16'h0C8A) → after reset all outputs are at their reset values; first `cs_n` fall at cycle 82; `cs_n` low for 64 cycles; `listo` pulses one cycle, 65 cycles after `cs_n` fall; `y`=11'd1605 (0x645).
- **Back-to-back samples:** ADC model returns codes 0xFFF then 0x001 → `y`=2047, then `y`=0; strobes are exactly 82 cycles apart.
- **Enable control:** `en` dropped 10 cycles into SHIFT → that frame completes with a normal `listo`; no further `cs_n` activity. `en` raised again → next `cs_n` fall 82 cycles later.
- **Reset mid-frame:** `rst` asserted low at `hp`=17 → `cs_n` and `sclk` go high immediately; no `listo`; `y`=0. After release, a normal frame follows.
- **SCLK protocol check:** monitor counts exactly 16 SCLK rising edges per `cs_n` low window and checks each SCLK phase is 2 cycles → pass. Leading bits driven to 1 (frame 16'hF7FE) → `y`=11'd1023, leading bits ignored.
- **Closed loop with the controller:** `IPD_trunc` connected to the block, r=100, default parameters scaled down to DIV=1, SAMPLE_PERIOD=50 → controller sees ≥16 cycles between `listo` pulses, and `trunc` changes only after strobes.
